serv_csr_mirq: RTL and testbench

Bit-serial machine-mode CSR unit for the SERV core with a parametrised number of local interrupt lines. It holds mstatus.MIE/MPIE, an NIRQ-bit mie register, a read-only mip view, and a 5-bit mcause code plus interrupt flag. It arbitrates pending interrupts by fixed priority and reports a new interrupt to the state machine at instruction boundaries. It sits between the decoder/state block and the register-file CSR port, one bit per cycle.

---
 rtl/serv_csr_mirq.sv | 176 +++++++++++++++++
 tb/tb_serv_csr_mirq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_csr_mirq.sv
// Bit-serial machine-mode CSR unit for SERV with NIRQ prioritised local interrupt lines.
// Optional: define SERV_CSR_IRQ_EDGE_EN for legacy once-per-assertion interrupt qualification.

module serv_csr_mirq_line #(
  parameter logic [4:0] POS = 5'd7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_cnt,
  input  logic       i_mie_wen,
  input  logic       i_csr_in,
  input  logic       i_irq,
  output logic       o_mie,
  output logic       o_mie_q,
  output logic       o_mip_q
);
  logic hit;
  assign hit = (i_cnt == POS);

  always_ff @(posedge i_clk) begin
    if (i_rst)                 o_mie <= 1'b0;
    else if (i_mie_wen & hit)  o_mie <= i_csr_in;
  end

  assign o_mie_q = o_mie & hit;
  assign o_mip_q = i_irq & hit;
endmodule

module serv_csr_mirq #(
  parameter int NIRQ = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_init,
  input  logic            i_en,
  input  logic [4:0]      i_cnt,
  input  logic            i_cnt_done,
  input  logic            i_trap,
  input  logic            i_mret,
  input  logic            i_e_op,
  input  logic            i_ebreak,
  input  logic            i_mem_op,
  input  logic            i_mem_cmd,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_mstatus_en,
  input  logic            i_mie_en,
  input  logic            i_mip_en,
  input  logic            i_mcause_en,
  input  logic [1:0]      i_csr_source,
  input  logic            i_csr_d_sel,
  input  logic            i_csr_imm,
  input  logic            i_rs1,
  input  logic            i_rf_csr_out,
  output logic            o_csr_in,
  output logic            o_q,
  output logic            o_new_irq,
  output logic            o_irq_pending
);
  logic            mstatus_mie, mstatus_mpie, mcause31;
  logic [4:0]      mcause_code, irq_code, win_code, exc_code;
  logic [NIRQ-1:0] mie, mie_q, mip_q, pend, qpend;
  logic [15:0]     qp16;
  logic            d, mstatus_q, mcause_q, trap_done, boundary;

  assign d         = i_csr_d_sel ? i_csr_imm : i_rs1;
  assign trap_done = i_trap & i_cnt_done;
  assign boundary  = !i_init & i_cnt_done;

  genvar k;
  generate
    for (k = 0; k < NIRQ; k++) begin : g_line
      localparam logic [4:0] P = (k == 0) ? 5'd7 : (k == 1) ? 5'd3 :
                                 (k == 2) ? 5'd11 : 5'(13 + k);
      serv_csr_mirq_line #(.POS(P)) u_line (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cnt     (i_cnt),
        .i_mie_wen (i_mie_en & i_en),
        .i_csr_in  (o_csr_in),
        .i_irq     (i_irq[k]),
        .o_mie     (mie[k]),
        .o_mie_q   (mie_q[k]),
        .o_mip_q   (mip_q[k])
      );
    end
  endgenerate

  assign mstatus_q = i_mstatus_en & i_en &
                     (((i_cnt == 5'd3) & mstatus_mie) | ((i_cnt == 5'd7) & mstatus_mpie));
  // Low five bits stream out of the shifting code register; bit 31 appears on the last bit.
  assign mcause_q  = i_mcause_en & i_en &
                     (((i_cnt < 5'd5) & mcause_code[0]) | (i_cnt_done & mcause31));

  assign o_q = i_rf_csr_out | mstatus_q | mcause_q |
               (i_mie_en & i_en & (|mie_q)) | (i_mip_en & i_en & (|mip_q));

  always_comb begin
    case (i_csr_source)
      2'b01:   o_csr_in = d;
      2'b10:   o_csr_in = o_q | d;
      2'b11:   o_csr_in = o_q & ~d;
      default: o_csr_in = o_q;
    endcase
  end

  assign pend          = i_irq & mie;
  assign o_irq_pending = |pend;

`ifdef SERV_CSR_IRQ_EDGE_EN
  logic [NIRQ-1:0] pend_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)         pend_q <= '0;
    else if (boundary) pend_q <= pend;
  end
  assign qpend = pend & ~pend_q;
`else
  assign qpend = pend;
`endif

  // Later assignments override earlier ones, so the loop order encodes priority.
  always_comb begin
    qp16 = '0;
    qp16[NIRQ-1:0] = qpend;
    win_code = 5'd0;
    for (int i = 15; i >= 3; i--)
      if (qp16[i]) win_code = 5'(13 + i);
    if (qp16[0]) win_code = 5'd7;
    if (qp16[1]) win_code = 5'd3;
    if (qp16[2]) win_code = 5'd11;
  end

  always_comb begin
    exc_code = 5'd0;
    if (i_e_op)        exc_code = i_ebreak ? 5'd3 : 5'd11;
    else if (i_mem_op) exc_code = i_mem_cmd ? 5'd6 : 5'd4;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_done) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (i_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (i_mstatus_en & i_en) begin
      if (i_cnt == 5'd3) mstatus_mie  <= o_csr_in;
      if (i_cnt == 5'd7) mstatus_mpie <= o_csr_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcause31    <= 1'b0;
      mcause_code <= 5'd0;
    end else if (trap_done) begin
      mcause31    <= o_new_irq;
      mcause_code <= o_new_irq ? irq_code : exc_code;
    end else if (i_mcause_en & i_en) begin
      if (i_cnt < 5'd5) mcause_code <= {o_csr_in, mcause_code[4:1]};
      if (i_cnt_done)   mcause31    <= o_csr_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_new_irq <= 1'b0;
      irq_code  <= 5'd0;
    end else if (boundary) begin
      o_new_irq <= mstatus_mie & (|qpend);
      irq_code  <= win_code;
    end
  end
endmodule

// File: tb/tb_serv_csr_mirq.sv
// Scoreboard bench for serv_csr_mirq: word-level reference model, queued expectations, decoupled monitor.
module tb_serv_csr_mirq;
  localparam int NIRQ = 8;

  logic            i_clk = 1'b0;
  logic            i_rst, i_init, i_en, i_cnt_done, i_trap, i_mret;
  logic            i_e_op, i_ebreak, i_mem_op, i_mem_cmd;
  logic [4:0]      i_cnt;
  logic [NIRQ-1:0] i_irq;
  logic            i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
  logic [1:0]      i_csr_source;
  logic            i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out;
  logic            o_csr_in, o_q, o_new_irq, o_irq_pending;

  serv_csr_mirq #(.NIRQ(NIRQ)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt(i_cnt),
    .i_cnt_done(i_cnt_done), .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op),
    .i_ebreak(i_ebreak), .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd), .i_irq(i_irq),
    .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
    .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel),
    .i_csr_imm(i_csr_imm), .i_rs1(i_rs1), .i_rf_csr_out(i_rf_csr_out),
    .o_csr_in(o_csr_in), .o_q(o_q), .o_new_irq(o_new_irq), .o_irq_pending(o_irq_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { string name; logic [31:0] val; } item_t;
  item_t exp_q[$];
  item_t act_q[$];
  int ntests = 0;
  int nfail  = 0;

  // reference state, kept in architectural CSR word form
  logic [31:0] m_mie32, m_pendq;
  logic        m_MIE, m_MPIE, m_c31, m_new;
  logic [4:0]  m_code, m_icode;

  function automatic void push_exp(input string n, input logic [31:0] v);
    item_t it; it.name = n; it.val = v; exp_q.push_back(it);
  endfunction
  function automatic void push_act(input string n, input logic [31:0] v);
    item_t it; it.name = n; it.val = v; act_q.push_back(it);
  endfunction

  function automatic logic [31:0] imap(input logic [NIRQ-1:0] v);
    logic [31:0] m;
    int p;
    m = '0;
    for (int k = 0; k < NIRQ; k++) begin
      p = (k == 0) ? 7 : (k == 1) ? 3 : (k == 2) ? 11 : 13 + k;
      if (v[k]) m[p] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [4:0] winner(input logic [31:0] q);
    if (q[11]) return 5'd11;
    if (q[3])  return 5'd3;
    if (q[7])  return 5'd7;
    for (int b = 16; b < 32; b++) if (q[b]) return 5'(b);
    return 5'd0;
  endfunction

  function automatic void model_reset();
    m_mie32 = '0; m_pendq = '0; m_MIE = 0; m_MPIE = 0; m_c31 = 0; m_new = 0;
    m_code = '0; m_icode = '0;
  endfunction

  task automatic idle_inputs();
    i_en = 0; i_cnt = '0; i_cnt_done = 0; i_trap = 0; i_mret = 0; i_init = 0;
    i_e_op = 0; i_ebreak = 0; i_mem_op = 0; i_mem_cmd = 0;
    i_mstatus_en = 0; i_mie_en = 0; i_mip_en = 0; i_mcause_en = 0;
    i_csr_source = 2'b00; i_csr_d_sel = 0; i_csr_imm = 0; i_rs1 = 0; i_rf_csr_out = 0;
  endtask

  // sel: 0 none, 1 mstatus, 2 mie, 3 mip, 4 mcause; exq = {e_op, ebreak, mem_op, mem_cmd}
  task automatic op(input int sel, input logic [1:0] src, input logic [31:0] d,
                    input logic trap = 0, input logic mret = 0, input logic init = 0,
                    input logic [3:0] exq = 4'b0);
    logic [31:0] q, cin, rf, w, pend32, qual32;
    logic        dsel, nn;
    logic [4:0]  nc, exc;
    string       nm;
    dsel = 1'($urandom_range(0, 1));
    rf   = (sel == 0) ? $urandom : 32'h0;
    case (sel)
      1: begin nm = "rd_mstatus"; q = (32'(m_MPIE) << 7) | (32'(m_MIE) << 3); end
      2: begin nm = "rd_mie";     q = m_mie32; end
      3: begin nm = "rd_mip";     q = imap(i_irq); end
      4: begin nm = "rd_mcause";  q = {m_c31, 26'b0, m_code}; end
      default: begin nm = "rd_rf"; q = 32'h0; end
    endcase
    q = q | rf;
    case (src)
      2'b01:   cin = d;
      2'b10:   cin = q | d;
      2'b11:   cin = q & ~d;
      default: cin = q;
    endcase
    if (sel == 1) begin m_MIE = cin[3]; m_MPIE = cin[7]; end
    if (sel == 2) m_mie32 = cin & imap('1);
    if (sel == 4) begin m_code = cin[4:0]; m_c31 = cin[31]; end
    if (mret) begin m_MIE = m_MPIE; m_MPIE = 1'b1; end
    pend32 = imap(i_irq) & m_mie32;
`ifdef SERV_CSR_IRQ_EDGE_EN
    qual32 = pend32 & ~m_pendq;
`else
    qual32 = pend32;
`endif
    nn = m_MIE & (qual32 != 0);
    nc = winner(qual32);
    if (trap) begin
      exc = exq[3] ? (exq[2] ? 5'd3 : 5'd11) : exq[1] ? (exq[0] ? 5'd6 : 5'd4) : 5'd0;
      m_c31  = m_new;
      m_code = m_new ? m_icode : exc;
      m_MPIE = m_MIE;
      m_MIE  = 1'b0;
    end
    if (!init) begin m_new = nn; m_icode = nc; m_pendq = pend32; end
    push_exp(nm, q);
    push_exp("new_irq", 32'(m_new));
    push_exp("irq_pending", 32'(pend32 != 0));

    for (int c = 0; c < 32; c++) begin
      i_en = 1; i_cnt = 5'(c); i_cnt_done = (c == 31); i_init = init;
      i_mstatus_en = (sel == 1); i_mie_en = (sel == 2); i_mip_en = (sel == 3); i_mcause_en = (sel == 4);
      i_csr_source = src; i_csr_d_sel = dsel;
      i_rs1 = dsel ? ~d[c] : d[c]; i_csr_imm = dsel ? d[c] : ~d[c];
      i_rf_csr_out = rf[c]; i_trap = trap; i_mret = mret && (c == 0);
      {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = exq;
      @(negedge i_clk); w[c] = o_q;
      @(posedge i_clk); #1;
    end
    idle_inputs();
    push_act(nm, w);
    push_act("new_irq", 32'(o_new_irq));
    push_act("irq_pending", 32'(o_irq_pending));
  endtask

  task automatic do_reset(input int abort_at);
    for (int c = 0; c < abort_at; c++) begin
      i_en = 1; i_cnt = 5'(c); i_mie_en = 1; i_csr_source = 2'b01; i_rs1 = 1; i_csr_d_sel = 0;
      @(posedge i_clk); #1;
    end
    idle_inputs();
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    model_reset();
    push_exp("rst_new_irq", 32'h0);
    push_act("rst_new_irq", 32'(o_new_irq));
  endtask

  initial begin
    item_t a, e;
    forever begin
      @(negedge i_clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        ntests++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL %s: got %h, nothing expected", a.name, a.val);
        end else begin
          e = exp_q.pop_front();
          if (a.val !== e.val) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", e.name, a.val, e.val);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    i_irq = '0; i_rst = 1;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    do_reset(0);
    op(1, 2'b00, 0); op(2, 2'b00, 0); op(4, 2'b00, 0);

    // MEI beats MTI
    op(2, 2'b01, 32'h880); op(1, 2'b01, 32'h8);
    i_irq = 8'b101; op(0, 2'b00, 0);
    i_irq = '0; op(0, 2'b00, 0, 1'b1);
    op(4, 2'b00, 0); op(1, 2'b00, 0);

    // platform line 7 versus masked then unmasked MTI
    op(2, 2'b01, 32'h1 << 20); op(1, 2'b01, 32'h8);
    i_irq = 8'h81; op(0, 2'b00, 0); op(0, 2'b00, 0, 1'b1); op(4, 2'b00, 0);
    op(2, 2'b10, 32'h80); op(1, 2'b10, 32'h8); op(0, 2'b00, 0);
    op(0, 2'b00, 0, 1'b1); op(4, 2'b00, 0);

    // exceptions and mret
    i_irq = '0;
    op(0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 4'b1000); op(4, 2'b00, 0);
    op(0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 4'b1100); op(4, 2'b00, 0);
    op(0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 4'b0011); op(4, 2'b00, 0);
    op(0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 4'b0010); op(4, 2'b00, 0);
    op(0, 2'b00, 0, 1'b0, 1'b1); op(1, 2'b00, 0);

    // mip is read-only
    i_irq = 8'hA5; op(3, 2'b01, 32'hFFFF_FFFF); op(3, 2'b00, 0);

    // level held across mret
    op(2, 2'b01, 32'h8); op(1, 2'b01, 32'h8);
    i_irq = 8'h02; op(0, 2'b00, 0); op(0, 2'b00, 0, 1'b1);
    op(0, 2'b00, 0, 1'b0, 1'b1); op(0, 2'b00, 0); op(0, 2'b00, 0);
    op(0, 2'b00, 0, 1'b0, 1'b0, 1'b1);
    i_irq = '0; op(0, 2'b00, 0, 1'b0, 1'b0, 1'b1); op(0, 2'b00, 0);

    // reset in the middle of an mie write
    do_reset(20);
    op(2, 2'b00, 0); op(1, 2'b00, 0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      i_irq = NIRQ'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 5)
        op($urandom_range(1, 4), 2'($urandom_range(0, 3)), $urandom);
      else if (kind < 7)
        op(0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
      else if (kind == 7)
        op(0, 2'b00, 0, 1'b0, 1'b1);
      else
        op(0, 2'b00, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge i_clk);
    ntests++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
